// File: rtl/seq_add_ctrl_pkg.sv
// Shared ALU definitions for the sequential add/subtract controller:
// controller state encoding, slice width and operation encoding.
package seq_add_ctrl_pkg;

    // Width of the shared carry-lookahead slice; one slice pass per beat.
    localparam int SLICE_W = 8;

    // Operation select encoding as presented on op_sub.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Width of a counter that indexes 'beats' slice passes (at least one bit).
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage : seq_add_ctrl_pkg

// File: rtl/seq_add_ctrl_add8_slice.sv
// 8-bit add slice: the team's carry-lookahead block plus the sum XOR stage.
// Purely combinational; the controller reuses one instance across beats.

// Existing 8-bit carry-lookahead block: c_o[i] is the carry out of bit i.
module carry (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] c_o
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic       acc;
    logic       chain;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Flattened lookahead: each carry is the OR of every generate term
    // propagated up to bit i, plus the carry-in propagated through all bits.
    // NOTE: acc/chain are combinational temporaries updated with blocking
    // assignments and given a value at the top of the block, so the loop
    // reads the value just computed and no latch is inferred.
    always_comb begin
        c_o   = '0;
        acc   = 1'b0;
        chain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc   = gen[i];
            chain = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (chain & gen[j]);
                chain = chain & prop[j];
            end
            c_o[i] = acc | (chain & cin_i);
        end
    end

endmodule : carry

module add8_slice
    import seq_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic [SLICE_W-1:0] c;

    carry u_carry (
        .a_i   (a_i),
        .b_i   (b_i),
        .cin_i (cin_i),
        .c_o   (c)
    );

    // Each sum bit sees the carry into its position: cin for bit 0,
    // the lookahead carry of the bit below for the rest.
    assign sum_o  = a_i ^ b_i ^ {c[SLICE_W-2:0], cin_i};
    assign cout_o = c[SLICE_W-1];

endmodule : add8_slice

// File: rtl/seq_add_ctrl.sv
// Multi-cycle add/subtract controller. One shared 8-bit slice is stepped
// over WIDTH/8 beats, least-significant byte first, with the ripple carry
// held in a register between beats. Reports carry-out, signed overflow
// and zero alongside the result behind a valid/ready handshake.
module seq_add_ctrl
    import seq_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int                BEATS     = WIDTH / SLICE_W;
    localparam int                BEAT_W    = beat_width(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Operands and result are held as byte lanes so a beat index selects
    // its slice directly.
    typedef logic [BEATS-1:0][SLICE_W-1:0] lanes_t;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q,  beat_d;
    logic               carry_q, carry_d;
    lanes_t             a_q,     a_d;
    lanes_t             b_q,     b_d;
    lanes_t             res_q,   res_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;
    logic               zero_q,  zero_d;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               a_msb;
    logic               b_msb;

    add8_slice u_slice (
        .a_i    (a_q[beat_q]),
        .b_i    (b_q[beat_q]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Sign bits of A and of the effective (possibly inverted) B.
    assign a_msb = a_q[BEATS-1][SLICE_W-1];
    assign b_msb = b_q[BEATS-1][SLICE_W-1];

    // Next-state, datapath updates and flag capture for the three states.
    // NOTE: every _d signal takes its _q value first, so paths that do not
    // update a register simply hold it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = data_a;
                    // Subtraction is A + ~B + 1: invert B here, carry-in 1.
                    b_d     = (op_sub == OP_SUB) ? ~data_b : data_b;
                    carry_d = (op_sub == OP_SUB);
                    beat_d  = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                res_d[beat_q] = slice_sum;
                carry_d       = slice_cout;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    cout_d  = slice_cout;
                    ovf_d   = (a_msb == b_msb) && (slice_sum[SLICE_W-1] != a_msb);
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    // NOTE: non-blocking assignments let every register sample the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule : seq_add_ctrl

// File: tb/tb_seq_add_ctrl.sv
// Scoreboard bench for seq_add_ctrl: the driver pushes the expected
// response of each accepted operation; an independent monitor pops and
// compares whenever the controller hands a result over.
module tb_seq_add_ctrl;

    localparam int WIDTH = 32;
    localparam int BEATS = WIDTH / 8;

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             op_sub    = 1'b0;
    logic [WIDTH-1:0] data_a    = '0;
    logic [WIDTH-1:0] data_b    = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    seq_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        logic             z;
        int               acc;
    } exp_t;

    exp_t exp_q[$];

    logic hold_off  = 1'b0;
    logic force_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as numbers.
    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sbv, sr;
        longint unsigned ua, ub;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        if (op) begin
            sr   = sa - sbv;
            e.co = (ua >= ub);
        end else begin
            sr   = sa + sbv;
            e.co = ((ua + ub) > 64'hFFFF_FFFF);
        end
        e.ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.res = sr[31:0];
        e.z   = (e.res == 32'd0);
        e.acc = 0;
        return e;
    endfunction

    // Issue one operation; returns #1 after the accepting edge.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        op_sub   = op;
        data_a   = a;
        data_b   = b;
        @(posedge clock);
        #1;
        e     = model(op, a, b);
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        op_sub   = 1'($urandom_range(0, 1));
        data_a   = $urandom;
        data_b   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Consumer: random back-pressure unless a directed test takes over.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            out_ready = hold_off ? force_rdy : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on each rising out_valid, fields on each handover.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: result 0x%08h with empty scoreboard", result);
                    end else begin
                        check("latency", 32'(cyc - exp_q[0].acc), BEATS);
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result",    result,    e.res);
                    check("carry_out", 32'(carry_out), 32'(e.co));
                    check("overflow",  32'(overflow),  32'(e.ov));
                    check("zero",      32'(zero),      32'(e.z));
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] corners [6];
        logic [31:0] ra, rb;
        int          n;
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        corners[5] = 32'h0000_00FF;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_flags",     32'({carry_out, overflow, zero}), 32'd0);
        @(posedge clock);
        #1;

        // Directed arithmetic corners.
        send(1'b0, 32'h0000_00FF, 32'h0000_0001);
        send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        send(1'b1, 32'd5, 32'd7);
        send(1'b1, 32'd7, 32'd5);
        send(1'b1, 32'h8000_0000, 32'h0000_0001);
        drain();

        // Handshake: ignored requests while busy, result held under back-pressure.
        hold_off  = 1'b1;
        force_rdy = 1'b0;
        @(posedge clock);
        #1;
        send(1'b0, 32'h1234_5678, 32'h1111_1111);
        in_valid = 1'b1;
        op_sub   = 1'b1;
        data_a   = 32'hDEAD_BEEF;
        data_b   = 32'h0BAD_F00D;
        for (int i = 0; i < 6; i++) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_result",    result,         32'h2345_6789);
        end
        force_rdy = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("release_in_ready",  32'(in_ready),  32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        hold_off  = 1'b0;
        force_rdy = 1'b0;
        drain();

        // Wrap to zero with carry out; leaves carry_out and zero set.
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        drain();

        // Asynchronous reset part-way through an operation.
        send(1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result",    result,         32'd0);
        check("midrst_flags",     32'({carry_out, overflow, zero}), 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send(1'b0, 32'd3, 32'd4);
        drain();

        // Randomized operations mixed with corner operands.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            send(1'($urandom_range(0, 1)), ra, rb);
        end
        drain();

        n = 0;
        repeat (4) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_add_ctrl
